// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/acknowledge channel and
// the decoder-facing instruction valid/ready channel.
// master = fetch unit side, slave = memory + decoder side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [3:0]         OpCode;
    logic [INSTR_W-5:0] Operand;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output OpCode,
        output Operand,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  OpCode,
        input  Operand,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words from instruction memory
// over a req/ack handshake, latches them into the instruction register and
// presents opcode/operand to the decoder with a valid/ready handshake.
// Handles branch redirects and halt.
// Optional feature: define FETCH_TIMEOUT_EN to enable the memory-ack timeout,
// which raises a sticky fault and parks the unit in FAULT until reset.
module instruction_fetch_unit #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_fetch_unit_if.master bus,
    input  logic                   branch_en,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   halt,
    output logic [ADDR_W-1:0]      pc_out,
    output logic                   fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] ST_FAULT = 2'd3;
`endif

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             timeout_hit;

    // The next unacknowledged REQ cycle is the one that exhausts the budget.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Fetch sequencing: PC, instruction register and control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            ir_pc <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (branch_en) begin
                        pc <= branch_target;
                    end
                    if (!halt) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A branch restarts the request; a word acked in the
                    // same cycle belongs to the old path and is dropped.
                    if (branch_en) begin
                        pc <= branch_target;
                    end else if (bus.mem_ack) begin
                        ir    <= bus.mem_rdata;
                        ir_pc <= pc;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_VALID;
`ifdef FETCH_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        // FAULT presents reset values on every output but fault.
                        pc    <= '0;
                        ir    <= '0;
                        ir_pc <= '0;
                        state <= ST_FAULT;
`endif
                    end
                end
                ST_VALID: begin
                    // Branch flushes the presented word; with ready it still
                    // counts as accepted, and the target beats PC+1.
                    if (branch_en || bus.instr_ready) begin
                        if (branch_en) begin
                            pc <= branch_target;
                        end
                        state <= halt ? ST_IDLE : ST_REQ;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter for the outstanding request and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state != ST_REQ || branch_en || bus.mem_ack) begin
                wait_cnt <= '0;
            end else if (!timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == ST_REQ && !branch_en && !bus.mem_ack && timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign fault          = 1'b0;
`endif

    assign bus.mem_req     = (state == ST_REQ);
    assign bus.mem_addr    = (state == ST_REQ) ? pc : '0;
    assign bus.instr_valid = (state == ST_VALID);
    assign bus.OpCode      = ir[INSTR_W-1 -: 4];
    assign bus.Operand     = ir[INSTR_W-5:0];
    assign pc_out          = ir_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a cycle-level reference model of the fetch
// rules, a memory responder with programmable wait states, a per-cycle
// comparator and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    localparam int ADDR_W      = 8;
    localparam int INSTR_W     = 16;
    localparam int TIMEOUT_CYC = 15;

    localparam int PH_IDLE    = 0;
    localparam int PH_FETCH   = 1;
    localparam int PH_PRESENT = 2;
    localparam int PH_DEAD    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;
    logic [ADDR_W-1:0] pc_out;
    logic              fault;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .branch_en(branch_en), .branch_target(branch_target),
        .halt(halt), .pc_out(pc_out), .fault(fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [INSTR_W-1:0] mem [0:255];
    logic               mem_on   = 1'b1;
    int                 mem_wait = 0;

    initial begin
        int  wcnt;
        logic prev_req;
        logic [ADDR_W-1:0] last_addr;
        wcnt = 0;
        prev_req = 1'b0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (!prev_req || bus.mem_addr != last_addr) wcnt = 0;
            prev_req  = (bus.mem_req === 1'b1);
            last_addr = bus.mem_addr;
            if (bus.mem_req === 1'b1 && mem_on && wcnt >= mem_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                wcnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'hDEAD;
                if (bus.mem_req === 1'b1) wcnt++;
            end
        end
    end

    // ---------------- reference model ----------------
    int                 ph = PH_IDLE;
    logic [ADDR_W-1:0]  m_pc = '0;
    logic [ADDR_W-1:0]  m_pcout = '0;
    logic [INSTR_W-1:0] m_ir = '0;
    logic               m_fault = 1'b0;
    int                 m_wait = 0;
    bit                 m_live = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                ph = PH_IDLE; m_pc = '0; m_pcout = '0; m_ir = '0;
                m_fault = 1'b0; m_wait = 0; m_live = 1'b1;
            end else if (m_live) begin
                case (ph)
                    PH_IDLE: begin
                        if (branch_en) m_pc = branch_target;
                        if (!halt) begin ph = PH_FETCH; m_wait = 0; end
                    end
                    PH_FETCH: begin
                        if (branch_en) begin
                            m_pc = branch_target;
                            m_wait = 0;
                        end else if (bus.mem_ack) begin
                            m_ir    = bus.mem_rdata;
                            m_pcout = m_pc;
                            m_pc    = 8'((int'(m_pc) + 1) % 256);
                            ph      = PH_PRESENT;
                        end else begin
                            m_wait++;
`ifdef FETCH_TIMEOUT_EN
                            if (m_wait == TIMEOUT_CYC) begin
                                ph = PH_DEAD;
                                m_fault = 1'b1;
                            end
`endif
                        end
                    end
                    PH_PRESENT: begin
                        if (branch_en || bus.instr_ready) begin
                            if (branch_en) m_pc = branch_target;
                            ph = halt ? PH_IDLE : PH_FETCH;
                            m_wait = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle comparator ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("mem_req", 32'(bus.mem_req), 32'(ph == PH_FETCH));
                check("mem_addr", 32'(bus.mem_addr), 32'((ph == PH_FETCH) ? m_pc : 8'h00));
                check("instr_valid", 32'(bus.instr_valid), 32'(ph == PH_PRESENT));
                check("fault", 32'(fault), 32'(m_fault));
                if (ph == PH_PRESENT || ph == PH_DEAD) begin
                    check("OpCode", 32'(bus.OpCode), 32'((ph == PH_DEAD) ? 4'h0 : m_ir[15:12]));
                    check("Operand", 32'(bus.Operand), 32'((ph == PH_DEAD) ? 12'h000 : m_ir[11:0]));
                    check("pc_out", 32'(pc_out), 32'((ph == PH_DEAD) ? 8'h00 : m_pcout));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; branch_en = 1'b0; branch_target = '0; halt = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'((i * 16'h0101) ^ 16'h3C00);
        mem[8'h00] = 16'h1ABC;
        mem[8'h01] = 16'h2DEF;
        mem[8'hFF] = 16'h7F00;
        mem[8'h40] = 16'h9440;

        // Test 1: reset values, zero-wait back-to-back fetch
        mem_on = 1'b1; mem_wait = 0;
        do_reset();
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_opcode", 32'(bus.OpCode), 32'h0);
        check("rst_operand", 32'(bus.Operand), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_pc_out", 32'(pc_out), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        check("t1_req_c1", 32'(bus.mem_req), 32'h1);
        check("t1_addr_c1", 32'(bus.mem_addr), 32'h0);
        tick();
        check("t1_valid_c2", 32'(bus.instr_valid), 32'h1);
        check("t1_op_c2", 32'(bus.OpCode), 32'h1);
        check("t1_operand_c2", 32'(bus.Operand), 32'hABC);
        check("t1_pc_c2", 32'(pc_out), 32'h0);
        tick();
        check("t1_addr_c3", 32'(bus.mem_addr), 32'h1);
        tick();
        check("t1_op_c4", 32'(bus.OpCode), 32'h2);
        check("t1_operand_c4", 32'(bus.Operand), 32'hDEF);
        check("t1_pc_c4", 32'(pc_out), 32'h1);
        halt = 1'b1;
        tick();
        check("t1_idle_req", 32'(bus.mem_req), 32'h0);

        // Test 2: three memory wait states, consumer stalls four cycles
        mem[8'h00] = 16'h5123;
        mem_wait = 3;
        do_reset();
        tick_n(3);
        check("t2_req_wait", 32'(bus.mem_req), 32'h1);
        check("t2_addr_wait", 32'(bus.mem_addr), 32'h0);
        tick_n(2);
        check("t2_valid", 32'(bus.instr_valid), 32'h1);
        check("t2_op", 32'(bus.OpCode), 32'h5);
        check("t2_operand", 32'(bus.Operand), 32'h123);
        tick_n(4);
        check("t2_op_stall", 32'(bus.OpCode), 32'h5);
        check("t2_operand_stall", 32'(bus.Operand), 32'h123);
        bus.instr_ready = 1'b1; halt = 1'b1;
        tick();
        check("t2_idle_valid", 32'(bus.instr_valid), 32'h0);
        check("t2_idle_req", 32'(bus.mem_req), 32'h0);
        halt = 1'b0; bus.instr_ready = 1'b0;
        tick();
        check("t2_pc_once", 32'(bus.mem_addr), 32'h1);

        // Test 3: fetch at 0xFF wraps the PC
        mem_wait = 0;
        do_reset();
        halt = 1'b1;
        tick();
        branch_en = 1'b1; branch_target = 8'hFF; halt = 1'b0;
        tick();
        check("t3_addr_ff", 32'(bus.mem_addr), 32'hFF);
        branch_en = 1'b0; bus.instr_ready = 1'b1;
        tick();
        check("t3_pc_out_ff", 32'(pc_out), 32'hFF);
        check("t3_op", 32'(bus.OpCode), 32'h7);
        tick();
        check("t3_addr_wrap", 32'(bus.mem_addr), 32'h00);
        check("t3_req_wrap", 32'(bus.mem_req), 32'h1);

        // Test 4: branch with ack, branch in VALID, branch with ready
        mem[8'h00] = 16'h1ABC;
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        branch_en = 1'b1; branch_target = 8'h40;
        tick();
        check("t4_drop_valid", 32'(bus.instr_valid), 32'h0);
        check("t4_req_40", 32'(bus.mem_req), 32'h1);
        check("t4_addr_40", 32'(bus.mem_addr), 32'h40);
        branch_en = 1'b0;
        tick();
        check("t4_op_9", 32'(bus.OpCode), 32'h9);
        check("t4_pc_out_40", 32'(pc_out), 32'h40);
        bus.instr_ready = 1'b0; branch_en = 1'b1; branch_target = 8'h40;
        tick();
        check("t4_flush_valid", 32'(bus.instr_valid), 32'h0);
        check("t4_flush_addr", 32'(bus.mem_addr), 32'h40);
        branch_en = 1'b0;
        tick();
        bus.instr_ready = 1'b1; branch_en = 1'b1; branch_target = 8'h10;
        tick();
        check("t4_br_ready_addr", 32'(bus.mem_addr), 32'h10);
        branch_en = 1'b0;
        tick();

        // Test 5: halt during wait, then reset with an in-flight ack
        mem[8'h00] = 16'hC0DE;
        mem_wait = 3;
        do_reset();
        tick();
        halt = 1'b1;
        tick_n(4);
        check("t5_valid_halt", 32'(bus.instr_valid), 32'h1);
        check("t5_op", 32'(bus.OpCode), 32'hC);
        check("t5_operand", 32'(bus.Operand), 32'h0DE);
        bus.instr_ready = 1'b1;
        tick();
        check("t5_idle_req", 32'(bus.mem_req), 32'h0);
        check("t5_idle_valid", 32'(bus.instr_valid), 32'h0);
        bus.instr_ready = 1'b0;
        tick();
        check("t5_idle_req2", 32'(bus.mem_req), 32'h0);
        halt = 1'b0; mem_wait = 0;
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_req", 32'(bus.mem_req), 32'h0);
        check("t5_rst_valid", 32'(bus.instr_valid), 32'h0);
        check("t5_rst_op", 32'(bus.OpCode), 32'h0);
        check("t5_rst_operand", 32'(bus.Operand), 32'h0);
        rst = 1'b0;
        tick();
        check("t5_refetch_addr", 32'(bus.mem_addr), 32'h0);
        check("t5_refetch_req", 32'(bus.mem_req), 32'h1);

        // Test 6: branch during a wait, then memory never answers
        mem_on = 1'b0;
        do_reset();
        tick_n(2);
        branch_en = 1'b1; branch_target = 8'h22;
        tick();
        check("t6_addr_22", 32'(bus.mem_addr), 32'h22);
        check("t6_req_22", 32'(bus.mem_req), 32'h1);
        branch_en = 1'b0;
        tick_n(20);
`ifdef FETCH_TIMEOUT_EN
        check("t6_fault", 32'(fault), 32'h1);
        check("t6_req", 32'(bus.mem_req), 32'h0);
`else
        check("t6_fault", 32'(fault), 32'h0);
        check("t6_req", 32'(bus.mem_req), 32'h1);
        check("t6_addr", 32'(bus.mem_addr), 32'h22);
`endif
        branch_en = 1'b1; branch_target = 8'h55; halt = 1'b1;
        tick_n(2);
`ifdef FETCH_TIMEOUT_EN
        check("t6_fault_sticky", 32'(fault), 32'h1);
        check("t6_req_parked", 32'(bus.mem_req), 32'h0);
`else
        check("t6_fault_zero", 32'(fault), 32'h0);
        check("t6_req_55", 32'(bus.mem_req), 32'h1);
`endif
        mem_on = 1'b1;
        do_reset();
        check("t6_fault_cleared", 32'(fault), 32'h0);
        tick_n(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
